// File: rtl/snake_dir_scheduler_if.sv
// Handshake bundle between the PS/2 byte receiver / game engine side and the
// direction scheduler. The scheduler takes the slave view.
interface snake_dir_scheduler_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       game_tick;
  logic [2:0] direction;
  logic       dir_update;
  logic       reset_req;
  logic [2:0] q_count;
  logic       drop;

  modport master (
    output scan_code, scan_valid, game_tick,
    input  direction, dir_update, reset_req, q_count, drop
  );

  modport slave (
    input  scan_code, scan_valid, game_tick,
    output direction, dir_update, reset_req, q_count, drop
  );
endinterface

// File: rtl/snake_dir_scheduler.sv
// Scan-code to direction scheduler for the snake game.
// Decodes make / F0 break / E0 extended byte sequences, filters reversals and
// duplicates against the most recent pending direction, queues accepted turns
// and hands out one turn per game tick.
module snake_dir_scheduler #(
  parameter int unsigned QDEPTH         = 2,
  parameter int unsigned PREFIX_TIMEOUT = 50000,
  parameter int unsigned TW             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  snake_dir_scheduler_if.slave  sched_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_e;

  localparam logic [2:0] DIR_STOP = 3'b100;

  state_e      state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // Storage sized for the largest legal depth so the 2-bit pointers index it
  // exactly; only the first QDEPTH entries are ever used.
  logic [1:0]  mem_q [4];
  logic [1:0]  mem_d [4];
  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic [2:0]  dir_q, dir_d;
  logic        upd_q, upd_d;
  logic        rr_q, rr_d;
  logic        drop_q, drop_d;

  logic        cand_v;
  logic [1:0]  cand;
  logic        space;
  logic [1:0]  last_idx;
  logic [2:0]  ref_dir;
  logic        opposite;
  logic        accept;
  logic        full;
  logic        push;
  logic        pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(QDEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Prefix FSM: byte decoding plus abandonment of stale prefixes.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    cand_v  = 1'b0;
    cand    = 2'b00;
    space   = 1'b0;
    if (sched_if.scan_valid) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          case (sched_if.scan_code)
            8'hF0: state_d = S_BRK;
            8'hE0: state_d = S_EXT;
            8'h1D: begin cand_v = 1'b1; cand = 2'b11; end
            8'h1C: begin cand_v = 1'b1; cand = 2'b10; end
            8'h1B: begin cand_v = 1'b1; cand = 2'b01; end
            8'h23: begin cand_v = 1'b1; cand = 2'b00; end
            8'h29: space = 1'b1;
            default: ;
          endcase
        end
        S_EXT: begin
          state_d = S_IDLE;
          case (sched_if.scan_code)
            8'hF0: state_d = S_EXT_BRK;
            8'h75: begin cand_v = 1'b1; cand = 2'b11; end
            8'h6B: begin cand_v = 1'b1; cand = 2'b10; end
            8'h72: begin cand_v = 1'b1; cand = 2'b01; end
            8'h74: begin cand_v = 1'b1; cand = 2'b00; end
            default: ;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (tmo_q == TW'(PREFIX_TIMEOUT - 1)) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Acceptance filter against the newest pending direction, and queue control.
  always_comb begin
    last_idx = (tail_q == 2'd0) ? 2'(QDEPTH - 1) : tail_q - 2'd1;
    ref_dir  = (count_q != 3'd0) ? {1'b0, mem_q[last_idx]} : dir_q;
    // up(11)/down(01) and left(10)/right(00) differ only in bit 1.
    opposite = !ref_dir[2] && (ref_dir[0] == cand[0]) && (ref_dir[1] != cand[1]);
    accept   = cand_v && !opposite && (ref_dir != {1'b0, cand});
    full     = (count_q == 3'(QDEPTH));
    push     = accept && !full;
    pop      = sched_if.game_tick && (count_q != 3'd0) && !space;

    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dir_d   = dir_q;
    upd_d   = 1'b0;
    rr_d    = 1'b0;
    drop_d  = 1'b0;

    if (space) begin
      head_d  = 2'd0;
      tail_d  = 2'd0;
      count_d = 3'd0;
      dir_d   = DIR_STOP;
      rr_d    = 1'b1;
    end else begin
      drop_d = accept && full;
      if (push) begin
        mem_d[tail_q] = cand;
        tail_d        = ptr_inc(tail_q);
      end
      if (pop) begin
        dir_d  = {1'b0, mem_q[head_q]};
        upd_d  = 1'b1;
        head_d = ptr_inc(head_q);
      end
      if (push && !pop)      count_d = count_q + 3'd1;
      else if (pop && !push) count_d = count_q - 3'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dir_q   <= DIR_STOP;
      upd_q   <= 1'b0;
      rr_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      upd_q   <= upd_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  assign sched_if.direction  = dir_q;
  assign sched_if.dir_update = upd_q;
  assign sched_if.reset_req  = rr_q;
  assign sched_if.q_count    = count_q;
  assign sched_if.drop       = drop_q;

endmodule

// File: tb/tb_snake_dir_scheduler.sv
// Bench for snake_dir_scheduler: every stimulus step pushes the expected
// output set to a scoreboard, which is popped and compared one cycle later.
module tb_snake_dir_scheduler;

  localparam int unsigned QD  = 2;
  localparam int unsigned TMO = 20;

  localparam logic [2:0] RT = 3'b000;
  localparam logic [2:0] DN = 3'b001;
  localparam logic [2:0] LF = 3'b010;
  localparam logic [2:0] UP = 3'b011;
  localparam logic [2:0] ST = 3'b100;

  logic clk;
  logic rst;

  snake_dir_scheduler_if ifc ();

  snake_dir_scheduler #(
    .QDEPTH         (QD),
    .PREFIX_TIMEOUT (TMO),
    .TW             (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sched_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] dir;
    logic       upd;
    logic       rr;
    logic [2:0] cnt;
    logic       drp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".direction"},  8'(ifc.direction),  8'(e.dir));
    check({e.tag, ".dir_update"}, 8'(ifc.dir_update), 8'(e.upd));
    check({e.tag, ".reset_req"},  8'(ifc.reset_req),  8'(e.rr));
    check({e.tag, ".q_count"},    8'(ifc.q_count),    8'(e.cnt));
    check({e.tag, ".drop"},       8'(ifc.drop),       8'(e.drp));
  endtask

  task automatic expect_now(input string tag, input logic [2:0] d, input logic u,
                            input logic r, input logic [2:0] c, input logic dr);
    sb.push_back('{tag, d, u, r, c, dr});
    compare_head();
  endtask

  // One clock of stimulus; outputs compared at the following falling edge.
  task automatic step(input logic sv, input logic [7:0] code, input logic tk,
                      input string tag, input logic [2:0] d, input logic u,
                      input logic r, input logic [2:0] c, input logic dr);
    sb.push_back('{tag, d, u, r, c, dr});
    ifc.scan_valid = sv;
    ifc.scan_code  = code;
    ifc.game_tick  = tk;
    @(posedge clk);
    #1;
    ifc.scan_valid = 1'b0;
    ifc.game_tick  = 1'b0;
    @(negedge clk);
    compare_head();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    ifc.scan_code  = 8'h00;
    ifc.scan_valid = 1'b0;
    ifc.game_tick  = 1'b0;
    idle(2);
    expect_now("reset", ST, 0, 0, 0, 0);
    rst = 1'b0;

    // Basic make code and release
    step(1, 8'h1D, 0, "up_key",    ST, 0, 0, 1, 0);
    step(0, 8'h00, 1, "tick_up",   UP, 1, 0, 0, 0);
    step(0, 8'h00, 0, "idle1",     UP, 0, 0, 0, 0);

    // Reversal rejection, then two queued turns
    step(1, 8'h1B, 0, "rev_down",  UP, 0, 0, 0, 0);
    step(1, 8'h1C, 0, "left_key",  UP, 0, 0, 1, 0);
    step(1, 8'h1B, 0, "down_key",  UP, 0, 0, 2, 0);
    step(0, 8'h00, 1, "tick_left", LF, 1, 0, 1, 0);
    step(0, 8'h00, 1, "tick_down", DN, 1, 0, 0, 0);
    step(0, 8'h00, 1, "tick_empty", DN, 0, 0, 0, 0);

    // Move to right, then duplicate rejection
    step(1, 8'h23, 0, "right_key", DN, 0, 0, 1, 0);
    step(0, 8'h00, 1, "tick_right", RT, 1, 0, 0, 0);
    step(1, 8'h23, 0, "dup_right", RT, 0, 0, 0, 0);

    // Fill queue, reversal against tail, drop when full
    step(1, 8'h1D, 0, "q_up",      RT, 0, 0, 1, 0);
    step(1, 8'h1C, 0, "q_left",    RT, 0, 0, 2, 0);
    step(1, 8'h23, 0, "q_rev_tail", RT, 0, 0, 2, 0);
    step(1, 8'hE0, 0, "q_e0",      RT, 0, 0, 2, 0);
    step(1, 8'h72, 0, "q_ext_down", RT, 0, 0, 2, 1);
    step(0, 8'h00, 0, "drop_clear", RT, 0, 0, 2, 0);

    // Key with tick on a full queue: dropped, pop still happens
    step(1, 8'h1B, 1, "full_tick", UP, 1, 0, 1, 1);
    // Key with tick, not full: tail (left) is the reference, count holds
    step(1, 8'h1B, 1, "push_pop",  LF, 1, 0, 1, 0);
    step(0, 8'h00, 1, "tick_dn2",  DN, 1, 0, 0, 0);

    // Break sequence discards the released key
    step(1, 8'hF0, 0, "brk_f0",    DN, 0, 0, 0, 0);
    step(1, 8'h1D, 0, "brk_1d",    DN, 0, 0, 0, 0);
    step(1, 8'h1C, 0, "post_brk",  DN, 0, 0, 1, 0);
    step(0, 8'h00, 1, "tick_lf2",  LF, 1, 0, 0, 0);

    // Extended break sequence
    step(1, 8'hE0, 0, "xbrk_e0",   LF, 0, 0, 0, 0);
    step(1, 8'hF0, 0, "xbrk_f0",   LF, 0, 0, 0, 0);
    step(1, 8'h75, 0, "xbrk_75",   LF, 0, 0, 0, 0);

    // One cycle short of the timeout: prefix still live, 1D ignored
    step(1, 8'hE0, 0, "tmo_e0a",   LF, 0, 0, 0, 0);
    idle(TMO - 1);
    step(1, 8'h1D, 0, "tmo_short", LF, 0, 0, 0, 0);
    // Full timeout: back to IDLE, 1D is a plain make code
    step(1, 8'hE0, 0, "tmo_e0b",   LF, 0, 0, 0, 0);
    idle(TMO);
    step(1, 8'h1D, 0, "tmo_full",  LF, 0, 0, 1, 0);

    // Space with tick on a two-entry queue
    step(1, 8'h23, 0, "sp_fill",   LF, 0, 0, 2, 0);
    step(1, 8'h29, 1, "space",     ST, 0, 1, 0, 0);
    step(0, 8'h00, 0, "space_end", ST, 0, 0, 0, 0);
    step(0, 8'h00, 1, "tick_stop", ST, 0, 0, 0, 0);

    // Asynchronous reset mid-sequence
    step(1, 8'h1D, 0, "r_up",      ST, 0, 0, 1, 0);
    step(0, 8'h00, 1, "r_tick",    UP, 1, 0, 0, 0);
    step(1, 8'h1C, 0, "r_left",    UP, 0, 0, 1, 0);
    step(1, 8'hE0, 0, "r_e0",      UP, 0, 0, 1, 0);
    rst = 1'b1;
    #1;
    expect_now("async_rst", ST, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 8'h74, 0, "post_rst_74", ST, 0, 0, 0, 0);
    step(0, 8'h00, 1, "post_rst_tick", ST, 0, 0, 0, 0);

    if (sb.size() != 0) check("scoreboard_leftover", 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
